alu_ctrl: RTL

Issue/writeback controller that sits directly upstream and downstream of the ALU. It accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from an internal 8×16 register file. It drives the ALU's op and operand inputs for exactly one cycle, then writes the ALU's registered result back to the destination register while reporting the result, the zero flag, and completion.

---
 rtl/alu_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// Issue/writeback controller wrapped around a registered ALU: accepts one
// instruction per 3 cycles, reads operands from an 8-entry register file and commits the result.
module alu_ctrl #(
  parameter int          DATA_W = 16,
  parameter logic [3:0]  LDI_OP = 4'd0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              err,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             instr_q, instr_d;
  logic [7:0][DATA_W-1:0]  rf_q;
  logic [DATA_W-1:0]       result_q, result_d;
  logic                    flag_z_q, flag_z_d;
  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;

  logic [3:0]              op;
  logic [2:0]              rd, ra, rb;
  logic [DATA_W-1:0]       imm_ext;
  logic                    is_ldi, is_alu;

  assign op      = instr_q[15:12];
  assign rd      = instr_q[11:9];
  assign ra      = instr_q[8:6];
  assign rb      = instr_q[5:3];
  assign imm_ext = {{(DATA_W-9){1'b0}}, instr_q[8:0]};
  assign is_ldi  = (op == LDI_OP);
  assign is_alu  = !is_ldi && (op >= 4'd1) && (op <= 4'd10);

  // Operands are read from the latched instruction; the write lands only at
  // the end of WB, so an aliased rd always sees pre-write values.
  assign alu_a    = rf_q[ra];
  assign alu_b    = rf_q[rb];
  assign dbg_data = rf_q[dbg_addr];
  assign result   = result_q;
  assign flag_z   = flag_z_q;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    in_ready = 1'b0;
    alu_op   = 4'd0;
    done     = 1'b0;
    err      = 1'b0;
    wr_en    = 1'b0;
    wr_data  = alu_out;
    result_d = result_q;
    flag_z_d = flag_z_q;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          state_d = ISSUE;
          instr_d = in_instr;
        end
      end
      ISSUE: begin
        // A zero opcode keeps the ALU holding its output for LDI/illegal.
        if (is_alu) alu_op = op;
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
        if (is_alu) begin
          wr_en    = 1'b1;
          wr_data  = alu_out;
          result_d = alu_out;
          flag_z_d = (alu_out == '0);
        end else if (is_ldi) begin
          wr_en    = 1'b1;
          wr_data  = imm_ext;
          result_d = imm_ext;
          flag_z_d = (imm_ext == '0);
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset)      rf_q     <= '0;
    else if (wr_en) rf_q[rd] <= wr_data;
  end

endmodule
